// File: rtl/int_seq_pkg.sv
// ---------------------------------------------------------------------------
// int_seq_pkg
// Shared definitions for the interrupt/reset sequencer that sits in front of
// the CPU decode stage: sequencer state type, default vector addresses and the
// BRK opcode that decode loads when an interrupt is forced.
// No ports (package).
// ---------------------------------------------------------------------------
package int_seq_pkg;

    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_IDLE = 3'd1,
        S_NMI  = 3'd2,
        S_IRQ  = 3'd3,
        S_BRK  = 3'd4
    } st_int;

    localparam logic [15:0] VEC_NMI_ADDR = 16'hFFFA;
    localparam logic [15:0] VEC_RST_ADDR = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ_ADDR = 16'hFFFE;

    localparam logic [7:0]  OP_BRK       = 8'h00;

endpackage

// File: rtl/int_seq_if.sv
// ---------------------------------------------------------------------------
// int_seq_if
// Bundle between decode and the interrupt sequencer.
//   master (decode side) drives: READY, SYNC, NMI, IRQ, i_flag, brk_op,
//                                vec_fetch, vec_done
//   slave  (int_seq)    drives: force_brk, vec_addr[15:0], b_flag,
//                                int_busy, nmi_ack
// ---------------------------------------------------------------------------
interface int_seq_if;

    logic        READY;
    logic        SYNC;
    logic        NMI;
    logic        IRQ;
    logic        i_flag;
    logic        brk_op;
    logic        vec_fetch;
    logic        vec_done;

    logic        force_brk;
    logic [15:0] vec_addr;
    logic        b_flag;
    logic        int_busy;
    logic        nmi_ack;

    modport master (
        output READY, SYNC, NMI, IRQ, i_flag, brk_op, vec_fetch, vec_done,
        input  force_brk, vec_addr, b_flag, int_busy, nmi_ack
    );

    modport slave (
        input  READY, SYNC, NMI, IRQ, i_flag, brk_op, vec_fetch, vec_done,
        output force_brk, vec_addr, b_flag, int_busy, nmi_ack
    );

endinterface

// File: rtl/int_seq_sync2.sv
// ---------------------------------------------------------------------------
// int_seq_sync2  (the sync2 synchronizer)
// Two-flop synchronizer for an asynchronous single-bit input.
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset, both flops clear to 0
//   d      in  asynchronous input
//   q      out synchronized output (two clocks of latency)
// ---------------------------------------------------------------------------
module int_seq_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            q_reg    <= 1'b0;
        end else begin
            meta_reg <= d;
            q_reg    <= meta_reg;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/int_seq.sv
// ---------------------------------------------------------------------------
// int_seq
// Interrupt/reset sequencer upstream of decode. Conditions NMI (edge) and
// IRQ (level, masked by the I flag), arbitrates reset > NMI > IRQ at opcode
// fetch, tracks software BRK, and supplies the vector address and B-flag for
// the status push. Late NMIs hijack an IRQ/BRK sequence up to the vector
// low-byte fetch.
// Ports:
//   i_clk  in  clock, rising edge
//   i_rst  in  asynchronous active-low reset
//   bus    int_seq_if.slave (decode handshake and sequencer outputs)
// Optional feature: define INT_SYNC_EN to pass NMI and IRQ through two-flop
// synchronizers before the edge/level logic (adds two cycles of latency).
// ---------------------------------------------------------------------------
module int_seq
    import int_seq_pkg::*;
#(
    parameter logic [15:0] VEC_NMI = VEC_NMI_ADDR,
    parameter logic [15:0] VEC_RST = VEC_RST_ADDR,
    parameter logic [15:0] VEC_IRQ = VEC_IRQ_ADDR
) (
    input  logic      i_clk,
    input  logic      i_rst,
    int_seq_if.slave  bus
);

    // bit 0 = NMI, bit 1 = IRQ
    logic [1:0] raw_in;
    logic [1:0] cond_in;

    assign raw_in = {bus.IRQ, bus.NMI};

`ifdef INT_SYNC_EN
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            int_seq_sync2 u_sync (
                .clk   (i_clk),
                .rst_n (i_rst),
                .d     (raw_in[gi]),
                .q     (cond_in[gi])
            );
        end
    endgenerate
`else
    assign cond_in = raw_in;
`endif

    logic nmi_in;
    logic irq_in;
    assign nmi_in = cond_in[0];
    assign irq_in = cond_in[1];

    st_int       state_reg,  state_next;
    logic [15:0] vec_addr_reg, vec_addr_next;
    logic        b_flag_reg, b_flag_next;
    logic        int_busy_reg;
    logic        nmi_ack_reg;
    logic        nmi_q_reg;
    logic        nmi_lat_reg, nmi_lat_next;

    logic irq_req;
    logic nmi_rise;
    logic nmi_vec_fetch;
    logic hijack;

    assign irq_req  = irq_in & ~bus.i_flag;
    assign nmi_rise = nmi_in & ~nmi_q_reg;

    // A pending NMI redirects an IRQ/BRK sequence only while the vector low
    // byte has not yet been fetched.
    assign hijack = bus.READY & bus.vec_fetch & nmi_lat_reg &
                    ((state_reg == S_IRQ) | (state_reg == S_BRK));

    // Vector fetch whose resulting vector is the NMI vector: acknowledges and
    // consumes the latched NMI.
    assign nmi_vec_fetch = (bus.READY & bus.vec_fetch & (state_reg == S_NMI)) | hijack;

    // A rising edge in the acknowledge cycle is a fresh request and survives.
    always_comb begin
        nmi_lat_next = nmi_lat_reg;
        if (state_reg == S_RST) begin
            nmi_lat_next = 1'b0;
        end else if (nmi_rise) begin
            nmi_lat_next = 1'b1;
        end else if (nmi_vec_fetch) begin
            nmi_lat_next = 1'b0;
        end
    end

    always_comb begin
        state_next    = state_reg;
        vec_addr_next = vec_addr_reg;
        b_flag_next   = b_flag_reg;
        if (bus.READY) begin
            case (state_reg)
                S_RST: begin
                    if (bus.vec_done) state_next = S_IDLE;
                end
                S_IDLE: begin
                    if (bus.SYNC && nmi_lat_reg) begin
                        state_next    = S_NMI;
                        vec_addr_next = VEC_NMI;
                        b_flag_next   = 1'b0;
                    end else if (bus.SYNC && irq_req) begin
                        state_next    = S_IRQ;
                        vec_addr_next = VEC_IRQ;
                        b_flag_next   = 1'b0;
                    end else if (bus.brk_op) begin
                        state_next    = S_BRK;
                        vec_addr_next = VEC_IRQ;
                        b_flag_next   = 1'b1;
                    end
                end
                S_NMI: begin
                    if (bus.vec_done) state_next = S_IDLE;
                end
                S_IRQ, S_BRK: begin
                    // b_flag is left alone on hijack: the status byte is
                    // already pushed with the original B value.
                    if (hijack) begin
                        state_next    = S_NMI;
                        vec_addr_next = VEC_NMI;
                    end else if (bus.vec_done) begin
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_RST;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_reg    <= S_RST;
            vec_addr_reg <= VEC_RST;
            b_flag_reg   <= 1'b0;
            int_busy_reg <= 1'b1;
            nmi_ack_reg  <= 1'b0;
            nmi_q_reg    <= 1'b0;
            nmi_lat_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            vec_addr_reg <= vec_addr_next;
            b_flag_reg   <= b_flag_next;
            int_busy_reg <= (state_next != S_IDLE);
            nmi_ack_reg  <= nmi_vec_fetch;
            nmi_q_reg    <= nmi_in;
            nmi_lat_reg  <= nmi_lat_next;
        end
    end

    assign bus.force_brk = bus.SYNC & bus.READY &
                           ((state_reg == S_RST) | nmi_lat_reg | irq_req);
    assign bus.vec_addr  = vec_addr_reg;
    assign bus.b_flag    = b_flag_reg;
    assign bus.int_busy  = int_busy_reg;
    assign bus.nmi_ack   = nmi_ack_reg;

endmodule

// File: tb/tb_int_seq.sv
// ---------------------------------------------------------------------------
// tb_int_seq
// Self-checking bench for int_seq (default build, INT_SYNC_EN undefined).
// Directed table of per-cycle vectors, hand-written READY/async-reset
// sequences, then randomized traffic against a behavioural model.
// ---------------------------------------------------------------------------
module tb_int_seq;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;

    int_seq_if bus_if ();

    int_seq dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus_if)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    // in    = {READY, SYNC, NMI, IRQ, i_flag, brk_op, vec_fetch, vec_done}
    // flags = {force_brk (with these inputs), b_flag, int_busy, nmi_ack}
    // flags/vec for registered outputs describe the state before this row's edge.
    typedef struct {
        logic [7:0]  in;
        logic [3:0]  flags;
        logic [15:0] vec;
    } row_t;

    row_t tbl [26];

    // ---------------- behavioural model ----------------
    localparam int M_RST  = 0;
    localparam int M_IDLE = 1;
    localparam int M_NMI  = 2;
    localparam int M_IRQ  = 3;
    localparam int M_BRK  = 4;

    int          m_mode;
    logic        m_pend;
    logic        m_prev;
    logic [15:0] m_vec;
    logic        m_b;
    logic        m_ack;
    int          m_nmi_taken;

    task automatic model_reset();
        m_mode = M_RST;
        m_pend = 1'b0;
        m_prev = 1'b0;
        m_vec  = 16'hFFFC;
        m_b    = 1'b0;
        m_ack  = 1'b0;
    endtask

    // Applies one rising clock edge with the inputs currently on the bus.
    task automatic model_update();
        logic rise, take, pend_n, irq_req;
        rise    = bus_if.NMI & ~m_prev;
        m_prev  = bus_if.NMI;
        irq_req = bus_if.IRQ & ~bus_if.i_flag;
        take    = bus_if.READY && bus_if.vec_fetch &&
                  (m_mode == M_NMI || ((m_mode == M_IRQ || m_mode == M_BRK) && m_pend));
        if (m_mode == M_RST)  pend_n = 1'b0;
        else if (rise)        pend_n = 1'b1;
        else if (take)        pend_n = 1'b0;
        else                  pend_n = m_pend;
        m_ack = take;
        if (take) m_nmi_taken++;
        if (bus_if.READY) begin
            if (m_mode == M_RST || m_mode == M_NMI) begin
                if (bus_if.vec_done) m_mode = M_IDLE;
            end else if (m_mode == M_IDLE) begin
                if (bus_if.SYNC && m_pend) begin
                    m_mode = M_NMI; m_vec = 16'hFFFA; m_b = 1'b0;
                end else if (bus_if.SYNC && irq_req) begin
                    m_mode = M_IRQ; m_vec = 16'hFFFE; m_b = 1'b0;
                end else if (bus_if.brk_op) begin
                    m_mode = M_BRK; m_vec = 16'hFFFE; m_b = 1'b1;
                end
            end else begin
                if (bus_if.vec_fetch && m_pend) begin
                    m_mode = M_NMI; m_vec = 16'hFFFA;
                end else if (bus_if.vec_done) begin
                    m_mode = M_IDLE;
                end
            end
        end
        m_pend = pend_n;
    endtask

    function automatic logic model_force();
        return bus_if.SYNC & bus_if.READY &
               ((m_mode == M_RST) | m_pend | (bus_if.IRQ & ~bus_if.i_flag));
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [7:0] v);
        bus_if.READY     = v[7];
        bus_if.SYNC      = v[6];
        bus_if.NMI       = v[5];
        bus_if.IRQ       = v[4];
        bus_if.i_flag    = v[3];
        bus_if.brk_op    = v[2];
        bus_if.vec_fetch = v[1];
        bus_if.vec_done  = v[0];
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_update();
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".force_brk"}, {15'd0, bus_if.force_brk}, {15'd0, model_force()});
        chk({tag, ".vec_addr"},  bus_if.vec_addr, m_vec);
        chk({tag, ".b_flag"},    {15'd0, bus_if.b_flag},   {15'd0, m_b});
        chk({tag, ".int_busy"},  {15'd0, bus_if.int_busy}, {15'd0, logic'(m_mode != M_IDLE)});
        chk({tag, ".nmi_ack"},   {15'd0, bus_if.nmi_ack},  {15'd0, m_ack});
    endtask

    initial begin
        tbl[0]  = '{8'b1100_0000, 4'b1010, 16'hFFFC}; // reset forces BRK
        tbl[1]  = '{8'b1000_0010, 4'b0010, 16'hFFFC}; // reset vec fetch: no ack
        tbl[2]  = '{8'b1000_0001, 4'b0010, 16'hFFFC}; // vec_done -> idle
        tbl[3]  = '{8'b1101_0000, 4'b1000, 16'hFFFC}; // IRQ at SYNC
        tbl[4]  = '{8'b1001_0010, 4'b0010, 16'hFFFE};
        tbl[5]  = '{8'b1000_0001, 4'b0010, 16'hFFFE};
        tbl[6]  = '{8'b1101_1000, 4'b0000, 16'hFFFE}; // IRQ masked by I
        tbl[7]  = '{8'b1010_0000, 4'b0000, 16'hFFFE}; // NMI pulse
        tbl[8]  = '{8'b1100_0000, 4'b1000, 16'hFFFE}; // NMI taken
        tbl[9]  = '{8'b1000_0010, 4'b0010, 16'hFFFA};
        tbl[10] = '{8'b1000_0000, 4'b0011, 16'hFFFA}; // nmi_ack pulse
        tbl[11] = '{8'b1000_0001, 4'b0010, 16'hFFFA};
        tbl[12] = '{8'b1100_0000, 4'b0000, 16'hFFFA}; // no second force
        tbl[13] = '{8'b1000_0100, 4'b0000, 16'hFFFA}; // software BRK
        tbl[14] = '{8'b1010_0000, 4'b0110, 16'hFFFE}; // NMI edge during BRK
        tbl[15] = '{8'b1000_0010, 4'b0110, 16'hFFFE}; // hijack at vec_fetch
        tbl[16] = '{8'b1000_0000, 4'b0111, 16'hFFFA};
        tbl[17] = '{8'b1000_0001, 4'b0110, 16'hFFFA};
        tbl[18] = '{8'b1011_0000, 4'b0100, 16'hFFFA}; // NMI and IRQ pending
        tbl[19] = '{8'b1111_0000, 4'b1100, 16'hFFFA}; // NMI wins
        tbl[20] = '{8'b1011_0010, 4'b0010, 16'hFFFA};
        tbl[21] = '{8'b1001_0001, 4'b0011, 16'hFFFA};
        tbl[22] = '{8'b1101_0000, 4'b1000, 16'hFFFA}; // IRQ on next SYNC
        tbl[23] = '{8'b1001_0010, 4'b0010, 16'hFFFE};
        tbl[24] = '{8'b1000_0001, 4'b0010, 16'hFFFE};
        tbl[25] = '{8'b1000_0000, 4'b0000, 16'hFFFE};

        m_nmi_taken = 0;
        model_reset();
        set_in(8'b0000_0000);

        // Reset state
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst.vec_addr", bus_if.vec_addr, 16'hFFFC);
        chk("rst.int_busy", {15'd0, bus_if.int_busy}, 16'd1);
        chk("rst.b_flag",   {15'd0, bus_if.b_flag},   16'd0);
        chk("rst.nmi_ack",  {15'd0, bus_if.nmi_ack},  16'd0);
        chk("rst.force_brk",{15'd0, bus_if.force_brk},16'd0);
        $display("reset: vec=%h busy=%b", bus_if.vec_addr, bus_if.int_busy);
        i_rst = 1'b1;
        tick();

        // Directed table
        for (int r = 0; r < 26; r++) begin
            set_in(tbl[r].in);
            @(negedge i_clk);
            $display("row %0d in=%b force=%b vec=%h b=%b busy=%b ack=%b", r, tbl[r].in,
                     bus_if.force_brk, bus_if.vec_addr, bus_if.b_flag, bus_if.int_busy, bus_if.nmi_ack);
            chk($sformatf("row%0d.force_brk", r), {15'd0, bus_if.force_brk}, {15'd0, tbl[r].flags[3]});
            chk($sformatf("row%0d.b_flag", r),    {15'd0, bus_if.b_flag},    {15'd0, tbl[r].flags[2]});
            chk($sformatf("row%0d.int_busy", r),  {15'd0, bus_if.int_busy},  {15'd0, tbl[r].flags[1]});
            chk($sformatf("row%0d.nmi_ack", r),   {15'd0, bus_if.nmi_ack},   {15'd0, tbl[r].flags[0]});
            chk($sformatf("row%0d.vec_addr", r),  bus_if.vec_addr, tbl[r].vec);
            tick();
        end

        // READY low at SYNC with IRQ pending: no force, state holds
        set_in(8'b0101_0000);
        @(negedge i_clk);
        chk("rdy0.force_brk", {15'd0, bus_if.force_brk}, 16'd0);
        tick();
        chk("rdy0.int_busy", {15'd0, bus_if.int_busy}, 16'd0);
        $display("ready-low SYNC: force=%b busy=%b", bus_if.force_brk, bus_if.int_busy);
        set_in(8'b1101_0000);
        @(negedge i_clk);
        chk("rdy1.force_brk", {15'd0, bus_if.force_brk}, 16'd1);
        tick();
        chk("irq.int_busy", {15'd0, bus_if.int_busy}, 16'd1);
        chk("irq.vec_addr", bus_if.vec_addr, 16'hFFFE);
        // vec_done with READY low must not end the sequence
        set_in(8'b0001_0001);
        tick();
        chk("rdy0_done.int_busy", {15'd0, bus_if.int_busy}, 16'd1);
        $display("irq entered, ready-low vec_done: busy=%b vec=%h", bus_if.int_busy, bus_if.vec_addr);

        // Asynchronous reset in the middle of the IRQ sequence
        set_in(8'b1001_0000);
        #2;
        i_rst = 1'b0;
        model_reset();
        #1;
        chk("arst.vec_addr", bus_if.vec_addr, 16'hFFFC);
        chk("arst.int_busy", {15'd0, bus_if.int_busy}, 16'd1);
        chk("arst.b_flag",   {15'd0, bus_if.b_flag},   16'd0);
        $display("async reset mid-IRQ: vec=%h busy=%b", bus_if.vec_addr, bus_if.int_busy);
        set_in(8'b0000_0000);
        @(negedge i_clk);
        i_rst = 1'b1;
        tick();

        // Randomized traffic against the model
        begin
            logic nmi_v, irq_v, ifl_v, rdy_v;
            int   pick;
            nmi_v = 1'b0; irq_v = 1'b0; ifl_v = 1'b0;
            for (int c = 0; c < 800; c++) begin
                rdy_v = ($urandom_range(0, 7) != 0);
                if ($urandom_range(0, 5) == 0) nmi_v = ~nmi_v;
                if ($urandom_range(0, 7) == 0) irq_v = ~irq_v;
                if ($urandom_range(0, 9) == 0) ifl_v = ~ifl_v;
                pick = $urandom_range(0, 9);
                bus_if.READY     = rdy_v;
                bus_if.NMI       = nmi_v;
                bus_if.IRQ       = irq_v;
                bus_if.i_flag    = ifl_v;
                bus_if.SYNC      = (pick <= 2);
                bus_if.brk_op    = (pick == 3);
                bus_if.vec_fetch = (pick == 4) && (m_mode != M_IDLE);
                bus_if.vec_done  = (pick == 5);
                @(negedge i_clk);
                chk_model($sformatf("rnd%0d", c));
                tick();
            end
            $display("random: 800 cycles, %0d NMI vector fetches", m_nmi_taken);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
